card_shuffler: RTL and testbench
================================

CARD_SHUFFLER -- requirements
Module: card_shuffler

Interface
REQ-001 Parameter DATA_W, default 4, bit width of one RAM word (card code).
REQ-002 Parameter ADDR_W, default 6, RAM address width.
REQ-003 Parameter DEPTH, default 52, number of words shuffled (addresses 0..DEPTH-1); the block SHALL require 2 <= DEPTH <= 2^ADDR_W.
REQ-004 Port clock  in  1  single clock; all state changes on rising edge.
REQ-005 Port reset_n  in  1  asynchronous, active-low reset.
REQ-006 Port start  in  1  level request from the control FSM; sampled only in IDLE.
REQ-007 Port mode  in  1  0 = random Fisher-Yates shuffle, 1 = deterministic reversal; latched at start.
REQ-008 Port seed  in  16  LFSR seed; latched at start.
REQ-009 Port rd_data  in  DATA_W  RAM read data, valid one cycle after the address is presented with wren=0.
REQ-010 Port mem_addr  out  ADDR_W  RAM address.
REQ-011 Port wr_data  out  DATA_W  RAM write data.
REQ-012 Port wren  out  1  RAM write enable; one write per cycle when high.
REQ-013 Port busy  out  1  high from start-accept until DONE is entered.
REQ-014 Port finish  out  1  high while in DONE.

Function
REQ-015 The FSM SHALL use states IDLE, PICK, RD_I, CAP_I, RD_J, CAP_J, WR_I, WR_J, NEXT, DONE.
REQ-016 In IDLE with start=1: latch mode; load LFSR with seed (seed 0 replaced by 16'hACE1); set i=DEPTH-1; go to PICK.
REQ-017 LFSR: 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1, shift right, feedback mask 16'hB400; advances only in PICK.
REQ-018 PICK, mode 0: candidate = LFSR & mask(i), where mask(i) = smallest 2^k-1 >= i; if candidate <= i then j=candidate and go to RD_I, else stay in PICK (retry next cycle).
REQ-019 PICK, mode 1: j=DEPTH-1-i, LFSR not advanced, always exactly one cycle.
REQ-020 RD_I: mem_addr=i, wren=0; CAP_I: register rd_data as word_i.
REQ-021 RD_J: mem_addr=j, wren=0; CAP_J: register rd_data as word_j.
REQ-022 WR_I: mem_addr=i, wr_data=word_j, wren=1; WR_J: mem_addr=j, wr_data=word_i, wren=1.
REQ-023 When j==i, WR_I and WR_J SHALL still occur with wren=0 (no writes, same cycle count).
REQ-024 NEXT: if i == last then go to DONE, else i=i-1 and go to PICK; last = 1 in mode 0, DEPTH/2 (integer division) in mode 1.
REQ-025 Per-index latency: exactly 8 cycles in mode 1; 8 plus retry count in mode 0.
REQ-026 DONE: finish=1, busy=0; remain until start=0, then go to IDLE.
REQ-027 start deassertion during an operation SHALL be ignored; the shuffle always completes.
REQ-028 wren SHALL be 0 in every state except WR_I/WR_J; mem_addr SHALL hold its last value in IDLE, NEXT, DONE.
REQ-029 All index arithmetic SHALL be ADDR_W bits; i never underflows below last.

Reset
REQ-030 reset_n=0 at any time, including mid-swap, SHALL immediately force IDLE, with mem_addr=0, wr_data=0, wren=0, busy=0, finish=0, i=0, j=0, LFSR=16'hACE1.
REQ-031 A swap interrupted by reset SHALL leave RAM partially written; no recovery is required.

Verification
REQ-032 DATA_W=6, mem[k]=k, mode=1, start held -> mem[k]=51-k, busy high for exactly 208 cycles, finish high 208 cycles after the accepting edge.
REQ-033 mode=0, seed=16'h1234, mem[k]=k -> final contents are a permutation of 0..51; every chosen j <= i; rerun with the same seed yields an identical result.
REQ-034 mode=0, seed=0 then seed=16'hACE1 -> identical final RAM contents.
REQ-035 start dropped after 20 cycles -> shuffle completes; finish asserts; return to IDLE one cycle after start=0 in DONE.
REQ-036 reset_n pulsed low during WR_I -> outputs zero asynchronously with no further wren; a new start runs a full shuffle.
REQ-037 DEPTH=2, mode=0 -> exactly one PICK/swap sequence with j in {0,1}; when j=1 wren stays 0 throughout.

Source files
------------

// File: rtl/card_shuffler_if.sv
// RAM port bundle between the card shuffler and its single-port RAM.
// The shuffler drives address/data/enable and the RAM returns read data.
interface card_shuffler_if #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 6
);
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wren;
  logic [DATA_W-1:0] rd_data;

  modport master (
    output mem_addr,
    output wr_data,
    output wren,
    input  rd_data
  );

  modport slave (
    input  mem_addr,
    input  wr_data,
    input  wren,
    output rd_data
  );
endinterface

// File: rtl/card_shuffler.sv
// In-place RAM shuffler: Fisher-Yates with a Galois LFSR, or a plain
// reversal; one read-read-write-write swap per index.
module card_shuffler #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 52
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  mode,
  input  logic [15:0]           seed,
  card_shuffler_if.master       mem,
  output logic                  busy,
  output logic                  finish
);

  typedef enum logic [3:0] {
    IDLE, PICK, RD_I, CAP_I, RD_J,
    CAP_J, WR_I, WR_J, NEXT, DONE
  } state_t;

  localparam logic [ADDR_W-1:0] TOP  = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] HALF = ADDR_W'(DEPTH / 2);
  localparam logic [ADDR_W-1:0] ONE  = ADDR_W'(1);
  localparam logic [15:0]       SEED0 = 16'hACE1;

  state_t            state, state_n;
  logic [ADDR_W-1:0] i, i_n, j, j_n;
  logic [15:0]       lfsr, lfsr_n, lfsr_adv;
  logic              mode_q, mode_n;
  logic [ADDR_W-1:0] mask, cand, last;
  logic [DATA_W-1:0] word_i;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdat_q;
  logic              wren_q;

  // Smear i rightwards to get the smallest all-ones mask covering it.
  always_comb begin
    mask = i;
    for (int k = 1; k < ADDR_W; k++) begin
      mask = mask | (i >> k);
    end
  end

  assign cand     = lfsr[ADDR_W-1:0] & mask;
  assign lfsr_adv = {1'b0, lfsr[15:1]}
                  ^ (lfsr[0] ? 16'hB400 : 16'h0000);
  assign last     = mode_q ? HALF : ONE;

  always_comb begin
    state_n = state;
    i_n     = i;
    j_n     = j;
    lfsr_n  = lfsr;
    mode_n  = mode_q;
    unique case (state)
      IDLE: begin
        if (start) begin
          mode_n  = mode;
          lfsr_n  = (seed == 16'h0) ? SEED0 : seed;
          i_n     = TOP;
          state_n = PICK;
        end
      end
      PICK: begin
        if (mode_q) begin
          j_n     = TOP - i;
          state_n = RD_I;
        end else begin
          lfsr_n = lfsr_adv;
          if (cand <= i) begin
            j_n     = cand;
            state_n = RD_I;
          end
        end
      end
      RD_I:  state_n = CAP_I;
      CAP_I: state_n = RD_J;
      RD_J:  state_n = CAP_J;
      CAP_J: state_n = WR_I;
      WR_I:  state_n = WR_J;
      WR_J:  state_n = NEXT;
      NEXT: begin
        if (i == last) begin
          state_n = DONE;
        end else begin
          i_n     = i - ONE;
          state_n = PICK;
        end
      end
      DONE: begin
        if (!start) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      i      <= '0;
      j      <= '0;
      lfsr   <= SEED0;
      mode_q <= 1'b0;
    end else begin
      state  <= state_n;
      i      <= i_n;
      j      <= j_n;
      lfsr   <= lfsr_n;
      mode_q <= mode_n;
    end
  end

  // Bus outputs are registered against the state being entered,
  // so the address holds wherever it is not explicitly reloaded.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      addr_q <= '0;
      wdat_q <= '0;
      wren_q <= 1'b0;
      word_i <= '0;
    end else begin
      unique case (1'b1)
        (state_n == RD_I) || (state_n == WR_I): addr_q <= i;
        (state_n == RD_J) || (state_n == WR_J): addr_q <= j;
        default: ;
      endcase
      wren_q <= ((state_n == WR_I) || (state_n == WR_J))
              && (i != j);
      if (state == CAP_I) word_i <= mem.rd_data;
      unique case (1'b1)
        state == CAP_J: wdat_q <= mem.rd_data;
        state == WR_I:  wdat_q <= word_i;
        default: ;
      endcase
    end
  end

  assign mem.mem_addr = addr_q;
  assign mem.wr_data  = wdat_q;
  assign mem.wren     = wren_q;
  assign busy         = (state != IDLE) && (state != DONE);
  assign finish       = (state == DONE);

endmodule

// File: tb/tb_card_shuffler.sv
// Directed bench: 52-card reversal and shuffle instance plus a 2-entry
// instance, each backed by a behavioural synchronous RAM.
module tb_card_shuffler;

  logic        clock;
  logic        reset_n;
  logic        start_a, mode_a, busy_a, finish_a;
  logic [15:0] seed_a;
  logic        start_b, mode_b, busy_b, finish_b;
  logic [15:0] seed_b;

  int checks;
  int failures;

  card_shuffler_if #(.DATA_W(6), .ADDR_W(6)) bus_a ();
  card_shuffler_if #(.DATA_W(4), .ADDR_W(1)) bus_b ();

  card_shuffler #(.DATA_W(6), .ADDR_W(6), .DEPTH(52)) dut_a (
    .clock   (clock),
    .reset_n (reset_n),
    .start   (start_a),
    .mode    (mode_a),
    .seed    (seed_a),
    .mem     (bus_a),
    .busy    (busy_a),
    .finish  (finish_a)
  );

  card_shuffler #(.DATA_W(4), .ADDR_W(1), .DEPTH(2)) dut_b (
    .clock   (clock),
    .reset_n (reset_n),
    .start   (start_b),
    .mode    (mode_b),
    .seed    (seed_b),
    .mem     (bus_b),
    .busy    (busy_b),
    .finish  (finish_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  logic [5:0] mem_a [52];
  logic [3:0] mem_b [2];
  logic       init_a, init_b;

  always @(posedge clock) begin
    if (init_a) begin
      for (int k = 0; k < 52; k++) mem_a[k] <= 6'(k);
    end else if (bus_a.wren && bus_a.mem_addr < 6'd52) begin
      mem_a[bus_a.mem_addr] <= bus_a.wr_data;
    end
    if (bus_a.mem_addr < 6'd52) bus_a.rd_data <= mem_a[bus_a.mem_addr];
    else bus_a.rd_data <= 6'h3F;
  end

  always @(posedge clock) begin
    if (init_b) begin
      mem_b[0] <= 4'd0;
      mem_b[1] <= 4'd1;
    end else if (bus_b.wren) begin
      mem_b[bus_b.mem_addr] <= bus_b.wr_data;
    end
    bus_b.rd_data <= mem_b[bus_b.mem_addr];
  end

  // WR_I/WR_J come as a back-to-back write pair: second address is j.
  int   jviol, npairs;
  logic prev_wren;
  logic [5:0] prev_addr;
  initial begin
    jviol = 0;
    npairs = 0;
    prev_wren = 1'b0;
    prev_addr = '0;
  end
  always @(posedge clock) begin
    if (bus_a.wren && prev_wren) begin
      npairs = npairs + 1;
      if (bus_a.mem_addr > prev_addr) jviol = jviol + 1;
    end
    prev_wren = bus_a.wren;
    prev_addr = bus_a.mem_addr;
  end

  logic [5:0] snap [52];

  task automatic load_a();
    @(negedge clock) init_a = 1'b1;
    @(negedge clock) init_a = 1'b0;
  endtask

  task automatic load_b();
    @(negedge clock) init_b = 1'b1;
    @(negedge clock) init_b = 1'b0;
  endtask

  task automatic run_a(input logic m, input logic [15:0] s,
                       input int drop_after,
                       output int busy_cyc, output bit done);
    @(negedge clock);
    mode_a  = m;
    seed_a  = s;
    start_a = 1'b1;
    busy_cyc = 0;
    done = 0;
    for (int c = 1; c <= 5000 && !done; c++) begin
      @(negedge clock);
      if (c == drop_after) start_a = 1'b0;
      if (busy_a) busy_cyc++;
      if (finish_a) done = 1;
    end
  endtask

  task automatic go_idle_a();
    start_a = 1'b0;
    @(negedge clock);
  endtask

  task automatic check_reversed(input string tag);
    int bad;
    bad = 0;
    for (int k = 0; k < 52; k++)
      if (mem_a[k] !== 6'(51 - k)) bad++;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL %s: %0d words not reversed (mem[0]=%0d need 51)",
               tag, bad, mem_a[0]);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #12;
    checks++;
    if ({bus_a.mem_addr, bus_a.wr_data, bus_a.wren, busy_a, finish_a}
        !== '0) begin
      failures++;
      $display("FAIL reset_a: addr=%0d data=%0d wren=%b busy=%b fin=%b",
               bus_a.mem_addr, bus_a.wr_data, bus_a.wren, busy_a,
               finish_a);
    end
    checks++;
    if ({bus_b.mem_addr, bus_b.wr_data, bus_b.wren, busy_b, finish_b}
        !== '0) begin
      failures++;
      $display("FAIL reset_b: outputs not zero");
    end
    @(negedge clock) reset_n = 1'b1;
    repeat (2) @(negedge clock);
    checks++;
    if (busy_a !== 1'b0 || finish_a !== 1'b0 || bus_a.wren !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_reset: busy=%b fin=%b wren=%b need 0",
               busy_a, finish_a, bus_a.wren);
    end
  endtask

  task automatic test_reversal();
    int  bc;
    bit  done;
    load_a();
    run_a(1'b1, 16'h0000, 0, bc, done);
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL rev_done: finish=%b need 1", finish_a);
    end
    checks++;
    if (bc != 208) begin
      failures++;
      $display("FAIL rev_busy_cycles: got %0d need 208", bc);
    end
    check_reversed("rev_contents");
    repeat (3) @(negedge clock);
    checks++;
    if (finish_a !== 1'b1 || busy_a !== 1'b0) begin
      failures++;
      $display("FAIL done_hold: fin=%b busy=%b need 1/0",
               finish_a, busy_a);
    end
    go_idle_a();
    checks++;
    if (finish_a !== 1'b0 || busy_a !== 1'b0) begin
      failures++;
      $display("FAIL done_release: fin=%b busy=%b need 0/0",
               finish_a, busy_a);
    end
  endtask

  task automatic test_random();
    int  bc, j0, p0, distinct, bad;
    bit  done;
    bit  seen [52];
    load_a();
    j0 = jviol;
    p0 = npairs;
    run_a(1'b0, 16'h1234, 0, bc, done);
    go_idle_a();
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL rand_done: finish never seen");
    end
    for (int k = 0; k < 52; k++) seen[k] = 0;
    distinct = 0;
    for (int k = 0; k < 52; k++) begin
      if (mem_a[k] < 6'd52 && !seen[mem_a[k]]) begin
        seen[mem_a[k]] = 1;
        distinct++;
      end
      snap[k] = mem_a[k];
    end
    checks++;
    if (distinct != 52) begin
      failures++;
      $display("FAIL rand_perm: %0d distinct codes need 52", distinct);
    end
    checks++;
    if (jviol != j0) begin
      failures++;
      $display("FAIL rand_j_le_i: %0d pairs with j>i need 0", jviol - j0);
    end
    checks++;
    if (npairs - p0 < 20) begin
      failures++;
      $display("FAIL rand_swaps: %0d swaps need >=20", npairs - p0);
    end
    checks++;
    if (bc < 8 * 51) begin
      failures++;
      $display("FAIL rand_busy: %0d cycles need >=408", bc);
    end
    load_a();
    run_a(1'b0, 16'h1234, 0, bc, done);
    go_idle_a();
    bad = 0;
    for (int k = 0; k < 52; k++) if (mem_a[k] !== snap[k]) bad++;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL rand_repeat: %0d words differ need 0", bad);
    end
  endtask

  task automatic test_seed_zero();
    int  bc, bad, same;
    bit  done;
    load_a();
    run_a(1'b0, 16'h0000, 0, bc, done);
    go_idle_a();
    same = 0;
    for (int k = 0; k < 52; k++) begin
      snap[k] = mem_a[k];
      if (mem_a[k] == 6'(k)) same++;
    end
    checks++;
    if (same == 52) begin
      failures++;
      $display("FAIL seed0_moved: contents unchanged need shuffled");
    end
    load_a();
    run_a(1'b0, 16'hACE1, 0, bc, done);
    go_idle_a();
    bad = 0;
    for (int k = 0; k < 52; k++) if (mem_a[k] !== snap[k]) bad++;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL seed0_equiv: %0d words differ need 0", bad);
    end
  endtask

  task automatic test_start_drop();
    int  bc;
    bit  done;
    load_a();
    run_a(1'b1, 16'h0000, 20, bc, done);
    checks++;
    if (!done || bc != 208) begin
      failures++;
      $display("FAIL drop_done: done=%0d busy=%0d need 1/208", done, bc);
    end
    check_reversed("drop_contents");
    @(negedge clock);
    checks++;
    if (finish_a !== 1'b0 || busy_a !== 1'b0) begin
      failures++;
      $display("FAIL drop_idle: fin=%b busy=%b need 0/0",
               finish_a, busy_a);
    end
  endtask

  task automatic test_reset_mid();
    int  bc, wcnt;
    bit  done, hit;
    load_a();
    @(negedge clock);
    mode_a  = 1'b1;
    start_a = 1'b1;
    hit = 0;
    for (int c = 0; c < 100 && !hit; c++) begin
      @(negedge clock);
      if (bus_a.wren === 1'b1) hit = 1;
    end
    checks++;
    if (!hit) begin
      failures++;
      $display("FAIL mid_wr_seen: wren never high within 100 cycles");
    end
    #1 reset_n = 1'b0;
    #1;
    checks++;
    if ({bus_a.mem_addr, bus_a.wr_data, bus_a.wren, busy_a, finish_a}
        !== '0) begin
      failures++;
      $display("FAIL mid_async: addr=%0d wren=%b busy=%b need 0",
               bus_a.mem_addr, bus_a.wren, busy_a);
    end
    start_a = 1'b0;
    wcnt = 0;
    repeat (3) begin
      @(negedge clock);
      if (bus_a.wren !== 1'b0) wcnt++;
    end
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
    if (bus_a.wren !== 1'b0) wcnt++;
    checks++;
    if (wcnt != 0) begin
      failures++;
      $display("FAIL mid_no_wren: %0d wren cycles need 0", wcnt);
    end
    load_a();
    run_a(1'b1, 16'h0000, 0, bc, done);
    go_idle_a();
    checks++;
    if (!done || bc != 208) begin
      failures++;
      $display("FAIL mid_rerun: done=%0d busy=%0d need 1/208", done, bc);
    end
    check_reversed("mid_rerun_contents");
  endtask

  task automatic run_b(input logic [15:0] s, input logic [3:0] e0,
                       input logic [3:0] e1, input int ewr,
                       input string tag);
    int  bc, wcnt;
    bit  done;
    load_b();
    @(negedge clock);
    mode_b  = 1'b0;
    seed_b  = s;
    start_b = 1'b1;
    bc = 0;
    wcnt = 0;
    done = 0;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clock);
      if (busy_b) bc++;
      if (bus_b.wren === 1'b1) wcnt++;
      if (finish_b) done = 1;
    end
    start_b = 1'b0;
    @(negedge clock);
    checks++;
    if (!done || bc != 8) begin
      failures++;
      $display("FAIL %s_cycles: done=%0d busy=%0d need 1/8", tag, done, bc);
    end
    checks++;
    if (wcnt != ewr) begin
      failures++;
      $display("FAIL %s_writes: %0d need %0d", tag, wcnt, ewr);
    end
    checks++;
    if (mem_b[0] !== e0 || mem_b[1] !== e1) begin
      failures++;
      $display("FAIL %s_mem: got %0d,%0d need %0d,%0d",
               tag, mem_b[0], mem_b[1], e0, e1);
    end
  endtask

  task automatic test_depth2();
    run_b(16'h1234, 4'd1, 4'd0, 2, "d2_swap");
    run_b(16'h0001, 4'd0, 4'd1, 0, "d2_self");
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    start_a  = 1'b0;
    mode_a   = 1'b0;
    seed_a   = '0;
    start_b  = 1'b0;
    mode_b   = 1'b0;
    seed_b   = '0;
    init_a   = 1'b0;
    init_b   = 1'b0;
    test_reset();
    test_reversal();
    test_random();
    test_seed_zero();
    test_start_drop();
    test_reset_mid();
    test_depth2();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
